// File: rtl/col_parity_engine_pkg.sv
// rtl/col_parity_engine_pkg.sv - shared shape defaults, FSM states and column-parity helper
package col_parity_engine_pkg;

    localparam int CPE_ROWS   = 5;
    localparam int CPE_COLS   = 5;
    localparam int CPE_DEPTH  = 64;
    localparam int CPE_LINE_W = CPE_ROWS * CPE_COLS;

    // Upper bounds let one helper serve any slice shape up to 16x16.
    localparam int MAX_ROWS   = 16;
    localparam int MAX_COLS   = 16;
    localparam int MAX_LINE_W = MAX_ROWS * MAX_COLS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_FINAL,
        ST_DONE
    } cpe_state_t;

    function automatic logic [MAX_COLS-1:0] col_parity(
        input logic [MAX_LINE_W-1:0] line,
        input int                    rows,
        input int                    cols
    );
        logic [MAX_COLS-1:0] c;
        c = '0;
        for (int y = 0; y < MAX_ROWS; y++) begin
            for (int x = 0; x < MAX_COLS; x++) begin
                if (y < rows && x < cols) begin
                    c[x] = c[x] ^ line[cols*y + x];
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/col_parity_engine_theta_slice.sv
// rtl/col_parity_engine_theta_slice.sv - combinational parity and theta mix for one slice
module theta_slice
    import col_parity_engine_pkg::*;
#(
    parameter int ROWS = CPE_ROWS,
    parameter int COLS = CPE_COLS
) (
    input  logic [ROWS*COLS-1:0] i_line,
    input  logic [COLS-1:0]      i_c_prev,
    input  logic                 i_mode,
    output logic [COLS-1:0]      o_c_cur,
    output logic [ROWS*COLS-1:0] o_out_line
);

    logic [MAX_LINE_W-1:0] w_line_ext;
    logic [MAX_COLS-1:0]   w_c_full;
    logic                  w_unused_hi;
    logic [COLS-1:0]       w_d;

    assign w_line_ext  = MAX_LINE_W'(i_line);
    assign w_c_full    = col_parity(w_line_ext, ROWS, COLS);
    assign o_c_cur     = w_c_full[COLS-1:0];
    assign w_unused_hi = ^w_c_full[MAX_COLS-1:COLS];

    always_comb begin
        w_d        = '0;
        o_out_line = '0;
        for (int x = 0; x < COLS; x++) begin
            w_d[x] = o_c_cur[(x + COLS - 1) % COLS] ^ i_c_prev[(x + 1) % COLS];
        end
        if (i_mode) begin
            for (int y = 0; y < ROWS; y++) begin
                for (int x = 0; x < COLS; x++) begin
                    o_out_line[COLS*y + x] = i_line[COLS*y + x] ^ w_d[x];
                end
            end
        end else begin
            o_out_line[COLS-1:0] = o_c_cur;
        end
    end

endmodule

// File: rtl/col_parity_engine.sv
// rtl/col_parity_engine.sv - self-sequenced in-place column-parity / theta sweep over slice memory
module col_parity_engine
    import col_parity_engine_pkg::*;
#(
    parameter int ROWS  = CPE_ROWS,
    parameter int COLS  = CPE_COLS,
    parameter int DEPTH = CPE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_mode,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_rd_en,
    output logic [AW-1:0]        o_rd_addr,
    input  logic [ROWS*COLS-1:0] i_rd_data,
    output logic                 o_wr_en,
    output logic [AW-1:0]        o_wr_addr,
    output logic [ROWS*COLS-1:0] o_wr_data
);

    localparam int LINE_W = ROWS * COLS;

    cpe_state_t        r_state, w_state_nxt;
    logic              r_mode;
    logic              r_rd_en;
    logic [AW-1:0]     r_rd_addr;
    logic              r_vld;
    logic [AW-1:0]     r_idx;
    logic [LINE_W-1:0] r_line0;
    logic [COLS-1:0]   r_c_prev;
    logic              r_wr_en;
    logic [AW-1:0]     r_wr_addr;
    logic [LINE_W-1:0] r_wr_data;

    logic              w_last_rd;
    logic              w_flush0;
    logic [LINE_W-1:0] w_theta_line;
    logic [COLS-1:0]   w_c_cur;
    logic [LINE_W-1:0] w_out_line;

    assign w_last_rd    = (r_rd_addr == AW'(DEPTH - 1));
    // Slice 0 is emitted once the read pipeline has emptied, when c_prev holds C_{DEPTH-1}.
    assign w_flush0     = (r_state == ST_DRAIN) && !r_vld;
    assign w_theta_line = w_flush0 ? r_line0 : i_rd_data;

    theta_slice #(.ROWS(ROWS), .COLS(COLS)) u_theta (
        .i_line     (w_theta_line),
        .i_c_prev   (r_c_prev),
        .i_mode     (r_mode),
        .o_c_cur    (w_c_cur),
        .o_out_line (w_out_line)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_READ;
            ST_READ:  if (r_rd_en && w_last_rd) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_vld) w_state_nxt = ST_FINAL;
            ST_FINAL: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_vld     <= 1'b0;
            r_idx     <= '0;
            r_line0   <= '0;
            r_c_prev  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_vld   <= r_rd_en;
            r_idx   <= r_rd_addr;
            r_wr_en <= 1'b0;

            if (r_state == ST_IDLE && i_start) begin
                r_mode    <= i_mode;
                r_rd_en   <= 1'b1;
                r_rd_addr <= '0;
            end else if (r_rd_en) begin
                if (w_last_rd) begin
                    r_rd_en   <= 1'b0;
                    r_rd_addr <= '0;
                end else begin
                    r_rd_addr <= r_rd_addr + AW'(1);
                end
            end

            if (r_vld) begin
                r_c_prev <= w_c_cur;
                if (r_idx == '0) begin
                    r_line0 <= i_rd_data;
                end else begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_idx;
                    r_wr_data <= w_out_line;
                end
            end else if (w_flush0) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= '0;
                r_wr_data <= w_out_line;
            end
        end
    end

    assign o_busy    = (r_state == ST_READ) || (r_state == ST_DRAIN) || (r_state == ST_FINAL);
    assign o_done    = (r_state == ST_DONE);
    assign o_rd_en   = r_rd_en;
    assign o_rd_addr = r_rd_addr;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;

endmodule

// File: tb/tb_col_parity_engine.sv
// tb/tb_col_parity_engine.sv - directed bench with slice memory and sweep reference model
module tb_col_parity_engine;

    localparam int ROWS  = 5;
    localparam int COLS  = 5;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LW    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic          i_mode;
    logic          o_busy;
    logic          o_done;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [LW-1:0] i_rd_data;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [LW-1:0] o_wr_data;

    always #5 clk = ~clk;

    col_parity_engine #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_mode    (i_mode),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_rd_en   (o_rd_en),
        .o_rd_addr (o_rd_addr),
        .i_rd_data (i_rd_data),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data)
    );

    logic [LW-1:0] mem      [DEPTH];
    logic [LW-1:0] img      [DEPTH];
    logic [LW-1:0] exp_line [DEPTH];
    bit            load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
        end else if (o_wr_en) begin
            mem[o_wr_addr] <= o_wr_data;
        end
        if (o_rd_en) i_rd_data <= mem[o_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int c0    = -1000;
    bit active = 1'b0;
    int wr_cnt, done_rel, last_wr_rel, last_wr_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Reference: column parities of every slice first, then each output line from its own and its predecessor's parity.
    function automatic void calc_exp(input bit m);
        logic [COLS-1:0] c [DEPTH];
        logic [COLS-1:0] prev;
        logic [LW-1:0]   line;
        for (int k = 0; k < DEPTH; k++) begin
            c[k] = '0;
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++)
                    c[k][x] = c[k][x] ^ img[k][COLS*y + x];
        end
        for (int k = 0; k < DEPTH; k++) begin
            prev = c[(k + DEPTH - 1) % DEPTH];
            line = img[k];
            if (m) begin
                for (int y = 0; y < ROWS; y++)
                    for (int x = 0; x < COLS; x++)
                        line[COLS*y + x] = img[k][COLS*y + x] ^ c[k][(x + COLS - 1) % COLS] ^ prev[(x + 1) % COLS];
                exp_line[k] = line;
            end else begin
                exp_line[k] = LW'(c[k]);
            end
        end
    endfunction

    always @(negedge clk) begin
        int rel;
        int wa;
        rel = cyc - c0;
        if (!i_rst_n) begin
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_rd_en", o_rd_en, 0);
            chk("rst_wr_en", o_wr_en, 0);
            chk("rst_rd_addr", o_rd_addr, 0);
            chk("rst_wr_addr", o_wr_addr, 0);
            chk("rst_wr_data", o_wr_data, 0);
        end else if (active && rel >= 1 && rel <= DEPTH + 4) begin
            chk("busy", o_busy, rel <= DEPTH + 3);
            chk("done", o_done, rel == DEPTH + 4);
            chk("rd_en", o_rd_en, rel <= DEPTH);
            if (rel <= DEPTH) chk("rd_addr", o_rd_addr, rel - 1);
            chk("wr_en", o_wr_en, rel >= 4 && rel <= DEPTH + 3);
            if (o_wr_en) begin
                wa = (rel <= DEPTH + 2) ? rel - 3 : 0;
                chk("wr_addr", o_wr_addr, wa);
                chk("wr_data", o_wr_data, exp_line[wa[AW-1:0]]);
                wr_cnt++;
                last_wr_rel  = rel;
                last_wr_addr = o_wr_addr;
            end
            if (o_done) done_rel = rel;
        end else begin
            chk("idle_busy", o_busy, 0);
            chk("idle_done", o_done, 0);
            chk("idle_rd_en", o_rd_en, 0);
            chk("idle_wr_en", o_wr_en, 0);
        end
    end

    task automatic load_img();
        @(posedge clk); #1;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic launch(input bit m);
        load_img();
        calc_exp(m);
        wr_cnt = 0; done_rel = -1; last_wr_rel = -1; last_wr_addr = -1;
        @(posedge clk); #1;
        i_start = 1'b1; i_mode = m; c0 = cyc; active = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic sweep(input bit m, input bit toggle_mode, input int pulse_at);
        int errs;
        launch(m);
        for (int i = 0; i < DEPTH + 6; i++) begin
            @(posedge clk); #1;
            if (toggle_mode) i_mode = ~i_mode;
            i_start = (i == pulse_at);
        end
        i_start = 1'b0;
        active = 1'b0;
        chk("wr_count", wr_cnt, DEPTH);
        chk("done_cycle", done_rel, DEPTH + 4);
        errs = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== exp_line[k]) errs++;
        chk("mem_image", errs, 0);
    endtask

    task automatic fill(input logic [LW-1:0] v);
        for (int k = 0; k < DEPTH; k++) img[k] = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1 i_start = 1'b1; i_mode = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        @(posedge clk); #1 i_rst_n = 1'b1;
        repeat (4) @(posedge clk);

        fill('0);
        sweep(1'b1, 1'b0, -1);
        chk("zero_last_wr_cycle", last_wr_rel, 67);
        chk("zero_last_wr_addr", last_wr_addr, 0);
        chk("zero_mem9", mem[9], 0);

        fill('0); img[5] = 25'h0000001;
        calc_exp(1'b1);
        chk("model_line5", exp_line[5], 25'h0210843);
        chk("model_line6", exp_line[6], 25'h1084210);
        sweep(1'b1, 1'b0, -1);
        chk("l5_mem5", mem[5], 25'h0210843);
        chk("l5_mem6", mem[6], 25'h1084210);
        chk("l5_mem7", mem[7], 0);
        chk("l5_mem0", mem[0], 0);

        fill('0); img[63] = 25'h0000001;
        sweep(1'b1, 1'b0, -1);
        chk("wrap_mem63", mem[63], 25'h0210843);
        chk("wrap_mem0", mem[0], 25'h1084210);
        chk("wrap_last_wr_cycle", last_wr_rel, 67);
        chk("wrap_last_wr_addr", last_wr_addr, 0);

        fill(25'h000001F);
        sweep(1'b0, 1'b1, -1);
        chk("par_mem0", mem[0], 25'h000001F);
        chk("par_mem33", mem[33], 25'h000001F);

        for (int k = 0; k < DEPTH; k++) img[k] = LW'($urandom);
        launch(1'b1);
        repeat (19) @(posedge clk);
        #1 i_rst_n = 1'b0; active = 1'b0;
        #1;
        chk("abort_wr_en", o_wr_en, 0);
        chk("abort_busy", o_busy, 0);
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        @(posedge clk); #1 i_rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int k = 0; k < DEPTH; k++) img[k] = LW'($urandom);
        sweep(1'b1, 1'b0, 10);

        for (int k = 0; k < DEPTH; k++) img[k] = LW'($urandom);
        sweep(1'b0, 1'b0, 30);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
